// File: rtl/cgra_prr_stream_stub_if.sv
// Stream bundle between GLB and one stub PRR: g2p/p2g data, handshakes, strobes.
// The master side is the GLB and the slave side is the PRR.
interface cgra_prr_stream_stub_if #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 16
);
  logic [NUM_CH*DATA_W-1:0] g2p_data;
  logic [NUM_CH-1:0]        g2p_vld;
  logic [NUM_CH-1:0]        g2p_flag;
  logic [NUM_CH-1:0]        g2p_rdy;
  logic [NUM_CH*DATA_W-1:0] p2g_data;
  logic [NUM_CH-1:0]        p2g_vld;
  logic [NUM_CH-1:0]        p2g_flag;
  logic [NUM_CH-1:0]        p2g_rdy;

  modport master (
    output g2p_data, g2p_vld, g2p_flag, p2g_rdy,
    input  g2p_rdy, p2g_data, p2g_vld, p2g_flag
  );

  modport slave (
    input  g2p_data, g2p_vld, g2p_flag, p2g_rdy,
    output g2p_rdy, p2g_data, p2g_vld, p2g_flag
  );
endinterface

// File: rtl/cgra_prr_stream_stub.sv
// CGRA PRR stand-in: per-channel FIFO loopback with rv or loop-scheduled p2g.
// Define CGRA_STUB_RAND_RDY_EN to gate rv handshakes with a per-channel LFSR.
module cgra_prr_stream_stub #(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 32,
  parameter int LOOP_LEVEL = 4,
  parameter int CFG_ADDR_W = 32,
  parameter int CFG_DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  cfg_wr_en,
  input  logic [CFG_ADDR_W-1:0] cfg_wr_addr,
  input  logic [CFG_DATA_W-1:0] cfg_wr_data,
  input  logic                  cfg_rd_en,
  input  logic [CFG_ADDR_W-1:0] cfg_rd_addr,
  output logic [CFG_DATA_W-1:0] cfg_rd_data,
  cgra_prr_stream_stub_if.slave s
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = CFG_DATA_W;

  logic [NUM_CH-1:0][DW-1:0] rd_ch;
  logic                      unused_addr;

  assign unused_addr = ^{cfg_wr_addr[CFG_ADDR_W-1:12],
                         cfg_rd_addr[CFG_ADDR_W-1:12]};

  always_comb begin
    cfg_rd_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (cfg_rd_en && cfg_rd_addr[11:8] == 4'(c)) begin
        cfg_rd_data = rd_ch[c];
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [5:0]                    ctrl_q;
    logic [DW-1:0]                 dim_q;
    logic [LOOP_LEVEL-1:0][DW-1:0] ext_q;
    logic [LOOP_LEVEL-1:0][DW-1:0] str_q;
    logic [DATA_W-1:0]             mem_q [FIFO_DEPTH];
    logic [PW-1:0]                 wp_q, wp_d;
    logic [PW-1:0]                 rp_q, rp_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic [DW-1:0]                 cyc_q, cyc_d;
    logic [LOOP_LEVEL-1:0][DW-1:0] idx_q, idx_d;
    logic [LOOP_LEVEL-1:0][DW-1:0] part_q, part_d;
    logic                          done_q, done_d;
    logic                          ovf_q, ovf_d;
    logic                          udf_q, udf_d;
    logic                          flag_q, flag_d;
    logic [DATA_W-1:0]             dout_q, dout_d;
    logic                          g2p_en, p2g_en;
    logic                          g2p_vm, g2p_rv;
    logic                          p2g_vm, p2g_rv;
    logic                          empty, full, rnd;
    logic                          g2p_rdy_w, p2g_vld_w;
    logic                          push_req, pop_req;
    logic                          push_do, pop_do;
    logic                          sched_on, hit, carry;
    logic [DATA_W-1:0]             din, head, pop_data;
    logic [DW-1:0]                 target, rd_w;
    logic [LOOP_LEVEL-1:0]         last;
    logic                          wr_hit;
    logic [7:0]                    wi, ri;

    assign wr_hit = cfg_wr_en && cfg_wr_addr[11:8] == 4'(c);
    assign wi     = cfg_wr_addr[7:0];
    assign ri     = cfg_rd_addr[7:0];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        ctrl_q <= '0;
        dim_q  <= '0;
        ext_q  <= '0;
        str_q  <= '0;
      end else if (wr_hit) begin
        if (wi == 8'd0) ctrl_q <= cfg_wr_data[5:0];
        if (wi == 8'd1) dim_q <= cfg_wr_data;
        for (int k = 0; k < LOOP_LEVEL; k++) begin
          if (wi == 8'(2 + k)) ext_q[k] <= cfg_wr_data;
          if (wi == 8'(2 + LOOP_LEVEL + k)) str_q[k] <= cfg_wr_data;
        end
      end
    end

    always_comb begin
      rd_w = '0;
      if (ri == 8'd0) rd_w = DW'(ctrl_q);
      if (ri == 8'd1) rd_w = dim_q;
      if (ri == 8'hFF) rd_w = DW'({udf_q, ovf_q, done_q, 16'(cnt_q)});
      for (int k = 0; k < LOOP_LEVEL; k++) begin
        if (ri == 8'(2 + k)) rd_w = ext_q[k];
        if (ri == 8'(2 + LOOP_LEVEL + k)) rd_w = str_q[k];
      end
    end

    assign rd_ch[c] = rd_w;

    assign g2p_en = ctrl_q[0];
    assign p2g_en = ctrl_q[1];
    assign g2p_vm = ctrl_q[3:2] == 2'd1;
    assign g2p_rv = ctrl_q[3:2] == 2'd2;
    assign p2g_vm = ctrl_q[5:4] == 2'd1;
    assign p2g_rv = ctrl_q[5:4] == 2'd2;

`ifdef CGRA_STUB_RAND_RDY_EN
    logic [15:0] lfsr_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        lfsr_q <= 16'hACE1 + 16'(c);
      end else if (!stall) begin
        lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5],
                   lfsr_q[15:1]};
      end
    end
    assign rnd = lfsr_q[0];
`else
    assign rnd = 1'b1;
`endif

    assign empty     = cnt_q == '0;
    assign full      = cnt_q == CW'(FIFO_DEPTH);
    assign din       = s.g2p_data[c*DATA_W +: DATA_W];
    assign head      = mem_q[rp_q];
    assign g2p_rdy_w = g2p_en & g2p_rv & ~full & ~stall & rnd;
    assign p2g_vld_w = p2g_en & p2g_rv & ~empty & ~stall & rnd;

    // Target is the sum of per-level partials, each tracking idx[k]*STRIDE[k].
    always_comb begin
      target = '0;
      last   = '0;
      for (int k = 0; k < LOOP_LEVEL; k++) begin
        if (k == 0 || DW'(k) < dim_q) begin
          target  = target + part_q[k];
          last[k] = idx_q[k] + DW'(1) >= ext_q[k];
        end else begin
          last[k] = 1'b1;
        end
      end
    end

    assign sched_on = p2g_en & p2g_vm & ~done_q;
    assign hit      = sched_on & ~stall & (cyc_q == target);

    assign push_req = g2p_rv ? (s.g2p_vld[c] & g2p_rdy_w)
                             : (g2p_vm & g2p_en & s.g2p_flag[c] & ~stall);
    assign pop_req  = p2g_rv ? (p2g_vld_w & s.p2g_rdy[c]) : hit;
    // A pop on an empty FIFO is served by a same-cycle push.
    assign pop_do   = pop_req & (~empty | push_req);
    assign push_do  = push_req & (~full | pop_do);
    assign pop_data = empty ? din : head;

    always_comb begin
      wp_d   = wp_q;
      rp_d   = rp_q;
      cnt_d  = cnt_q;
      cyc_d  = cyc_q;
      idx_d  = idx_q;
      part_d = part_q;
      done_d = done_q;
      ovf_d  = ovf_q;
      udf_d  = udf_q;
      flag_d = flag_q;
      dout_d = dout_q;
      carry  = 1'b1;
      if (flush) begin
        wp_d   = '0;
        rp_d   = '0;
        cnt_d  = '0;
        cyc_d  = '0;
        idx_d  = '0;
        part_d = '0;
        done_d = 1'b0;
        ovf_d  = 1'b0;
        udf_d  = 1'b0;
        flag_d = 1'b0;
        dout_d = '0;
      end else begin
        if (!stall) begin
          if (push_do) wp_d = wp_q + PW'(1);
          if (pop_do) rp_d = rp_q + PW'(1);
          if (push_do && !pop_do) cnt_d = cnt_q + CW'(1);
          if (pop_do && !push_do) cnt_d = cnt_q - CW'(1);
          if (push_req && !push_do) ovf_d = 1'b1;
          if (pop_req && !pop_do) udf_d = 1'b1;
          flag_d = hit;
          dout_d = (hit && pop_do) ? pop_data : '0;
          if (sched_on) cyc_d = cyc_q + DW'(1);
          if (hit) begin
            for (int k = 0; k < LOOP_LEVEL; k++) begin
              if (carry) begin
                if (last[k]) begin
                  idx_d[k]  = '0;
                  part_d[k] = '0;
                end else begin
                  idx_d[k]  = idx_q[k] + DW'(1);
                  part_d[k] = part_q[k] + str_q[k];
                  carry     = 1'b0;
                end
              end
            end
            done_d = carry;
          end
        end
        if (!p2g_en) begin
          cyc_d  = '0;
          idx_d  = '0;
          part_d = '0;
          done_d = 1'b0;
          flag_d = 1'b0;
          dout_d = '0;
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wp_q   <= '0;
        rp_q   <= '0;
        cnt_q  <= '0;
        cyc_q  <= '0;
        idx_q  <= '0;
        part_q <= '0;
        done_q <= 1'b0;
        ovf_q  <= 1'b0;
        udf_q  <= 1'b0;
        flag_q <= 1'b0;
        dout_q <= '0;
      end else begin
        wp_q   <= wp_d;
        rp_q   <= rp_d;
        cnt_q  <= cnt_d;
        cyc_q  <= cyc_d;
        idx_q  <= idx_d;
        part_q <= part_d;
        done_q <= done_d;
        ovf_q  <= ovf_d;
        udf_q  <= udf_d;
        flag_q <= flag_d;
        dout_q <= dout_d;
      end
    end

    always_ff @(posedge clk) begin
      if (push_do && !flush) mem_q[wp_q] <= din;
    end

    assign s.g2p_rdy[c]  = g2p_rdy_w;
    assign s.p2g_vld[c]  = p2g_vld_w;
    assign s.p2g_flag[c] = flag_q;
    assign s.p2g_data[c*DATA_W +: DATA_W] =
      (p2g_rv && !empty) ? head : dout_q;
  end
endmodule

// File: tb/tb_cgra_prr_stream_stub.sv
// Directed bench for cgra_prr_stream_stub: cfg map, rv loopback,
// loop schedule, overflow/underflow, stall/flush and async reset.
module tb_cgra_prr_stream_stub;
  localparam logic [7:0] ST = 8'hFF;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic        cfg_wr_en, cfg_rd_en;
  logic [31:0] cfg_wr_addr, cfg_wr_data, cfg_rd_addr, cfg_rd_data;
  logic [31:0] rd;
  int          n_tests = 0;
  int          n_fail = 0;
  int          nf, tog;
  int          exp_t [8] = '{0, 1, 2, 3, 10, 11, 12, 13};

  cgra_prr_stream_stub_if #(.NUM_CH(2), .DATA_W(16)) sif ();

  cgra_prr_stream_stub dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .flush      (flush),
    .cfg_wr_en  (cfg_wr_en),
    .cfg_wr_addr(cfg_wr_addr),
    .cfg_wr_data(cfg_wr_data),
    .cfg_rd_en  (cfg_rd_en),
    .cfg_rd_addr(cfg_rd_addr),
    .cfg_rd_data(cfg_rd_data),
    .s          (sif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ra(input int ch, input int r);
    return 32'((ch << 8) | r);
  endfunction

  task automatic cfg_wr(input logic [31:0] a, input logic [31:0] d);
    cfg_wr_en   = 1'b1;
    cfg_wr_addr = a;
    cfg_wr_data = d;
    @(posedge clk); #1;
    cfg_wr_en = 1'b0;
  endtask

  task automatic cfg_rd(input logic [31:0] a, output logic [31:0] d);
    cfg_rd_en   = 1'b1;
    cfg_rd_addr = a;
    #1;
    d = cfg_rd_data;
    cfg_rd_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic push_rv(input int n, input logic [15:0] base);
    int p = 0;
    for (int cyc = 0; cyc < 200 && p < n; cyc++) begin
      sif.g2p_vld[0] = 1'b1;
      sif.g2p_data[15:0] = base + 16'(p);
      #1;
      if (sif.g2p_rdy[0]) p++;
      @(posedge clk); #1;
    end
    sif.g2p_vld[0] = 1'b0;
    chk("push_cnt", p, n);
  endtask

  task automatic rv_loop(input int nw, input logic [15:0] base,
                         input bit rnd_rdy, output int toggles);
    int   pushed = 0;
    int   popped = 0;
    logic prev = 1'b0;
    toggles = 0;
    for (int cyc = 0; cyc < 2000 && popped < nw; cyc++) begin
      sif.g2p_vld[0] = pushed < nw;
      sif.g2p_data[15:0] = base + 16'(pushed);
      sif.p2g_rdy[0] = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (sif.g2p_rdy[0] != prev) toggles++;
      prev = sif.g2p_rdy[0];
      if (sif.g2p_vld[0] && sif.g2p_rdy[0]) pushed++;
      if (sif.p2g_vld[0] && sif.p2g_rdy[0]) begin
        chk("rv_data", 32'(sif.p2g_data[15:0]), 32'(base + 16'(popped)));
        popped++;
      end
      @(posedge clk); #1;
    end
    sif.g2p_vld[0] = 1'b0;
    sif.p2g_rdy[0] = 1'b0;
    chk("rv_count", popped, nw);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    cfg_wr_en = 1'b0; cfg_rd_en = 1'b0;
    cfg_wr_addr = '0; cfg_wr_data = '0; cfg_rd_addr = '0;
    sif.g2p_data = '0; sif.g2p_vld = '0;
    sif.g2p_flag = '0; sif.p2g_rdy = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_g2p_rdy", 32'(sif.g2p_rdy), 0);
    chk("rst_p2g_vld", 32'(sif.p2g_vld), 0);
    chk("rst_p2g_flag", 32'(sif.p2g_flag), 0);
    chk("rst_p2g_data", sif.p2g_data, 0);
    cfg_rd(ra(0, 0), rd);  chk("rst_ctrl", rd, 0);
    cfg_rd(ra(0, ST), rd); chk("rst_status", rd, 0);

    cfg_wr(ra(1, 0), 32'h2A);
    cfg_wr(ra(1, 3), 32'd5);
    cfg_rd(ra(1, 0), rd);    chk("ch1_ctrl", rd, 32'h2A);
    cfg_rd(ra(1, 3), rd);    chk("ch1_ext1", rd, 32'd5);
    cfg_rd(ra(2, 0), rd);    chk("bad_ch_rd", rd, 0);
    cfg_rd(ra(1, 8'h50), rd); chk("unmapped_rd", rd, 0);
    cfg_wr(ra(2, 0), 32'h3F);
    cfg_rd(ra(0, 0), rd);    chk("bad_ch_wr", rd, 0);
    cfg_wr(ra(1, ST), 32'hFFFF_FFFF);
    cfg_rd(ra(1, ST), rd);   chk("status_ro", rd, 0);
    cfg_rd_addr = ra(1, 0);
    #1 chk("rd_en_low", cfg_rd_data, 0);
    cfg_wr(ra(1, 0), 32'h0);

    cfg_wr(ra(0, 0), 32'h2B);
    rv_loop(8, 16'h0100, 1'b0, tog);
    cfg_rd(ra(0, ST), rd); chk("rv_status", rd, 0);
    rv_loop(100, 16'h4000, 1'b1, tog);
`ifdef CGRA_STUB_RAND_RDY_EN
    chk("rdy_toggles", 32'(tog > 4), 1);
`endif

    cfg_wr(ra(0, 0), 32'h09);
    push_rv(8, 16'h0200);
    cfg_rd(ra(0, ST), rd); chk("preload_cnt", rd, 8);
    cfg_wr(ra(0, 1), 32'd2);
    cfg_wr(ra(0, 2), 32'd4);
    cfg_wr(ra(0, 3), 32'd2);
    cfg_wr(ra(0, 6), 32'd1);
    cfg_wr(ra(0, 7), 32'd10);
    cfg_wr(ra(0, 0), 32'h12);
    nf = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (sif.p2g_flag[0]) begin
        if (nf < 8) begin
          chk("sched_cnt", k - 1, exp_t[nf]);
          chk("sched_data", 32'(sif.p2g_data[15:0]), 32'h200 + nf);
        end else begin
          chk("sched_extra", k - 1, 0);
        end
        nf++;
      end
    end
    chk("sched_flags", nf, 8);
    cfg_rd(ra(0, ST), rd); chk("sched_done", rd, 32'h0001_0000);

    cfg_wr(ra(0, 0), 32'h05);
    for (int i = 0; i < 33; i++) begin
      sif.g2p_flag[0] = 1'b1;
      sif.g2p_data[15:0] = 16'h0300 + 16'(i);
      @(posedge clk); #1;
    end
    sif.g2p_flag[0] = 1'b0;
    cfg_rd(ra(0, ST), rd); chk("ovf_status", rd, 32'h0002_0020);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    cfg_rd(ra(0, ST), rd); chk("flush_status", rd, 0);
    cfg_wr(ra(0, 0), 32'h12);
    @(posedge clk); #1;
    chk("udf_flag", 32'(sif.p2g_flag[0]), 1);
    chk("udf_data", 32'(sif.p2g_data[15:0]), 0);
    cfg_rd(ra(0, ST), rd); chk("udf_bit", (rd >> 18) & 32'h1, 1);
    repeat (20) @(posedge clk);
    #1;
    cfg_rd(ra(0, ST), rd); chk("udf_done", rd, 32'h0005_0000);

    cfg_wr(ra(0, 0), 32'h2B);
    push_rv(4, 16'h0500);
    cfg_rd(ra(0, ST), rd); chk("pre_stall", rd, 32'h0005_0004);
    stall = 1'b1;
    sif.g2p_vld[0] = 1'b1;
    sif.p2g_rdy[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_rdy", 32'(sif.g2p_rdy[0]), 0);
      chk("stall_vld", 32'(sif.p2g_vld[0]), 0);
      @(posedge clk); #1;
    end
    cfg_rd(ra(0, ST), rd); chk("stall_status", rd, 32'h0005_0004);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    stall = 1'b0;
    sif.g2p_vld[0] = 1'b0;
    sif.p2g_rdy[0] = 1'b0;
    #1 chk("post_flush_vld", 32'(sif.p2g_vld[0]), 0);
    cfg_rd(ra(0, ST), rd); chk("post_flush_st", rd, 0);
    cfg_rd(ra(0, 0), rd);  chk("ctrl_kept", rd, 32'h2B);
    cfg_rd(ra(0, 1), rd);  chk("dim_kept", rd, 32'd2);

    sif.g2p_vld[0] = 1'b1;
    #3 reset = 1'b1;
    cfg_rd_en = 1'b1;
    cfg_rd_addr = ra(0, 0);
    #1;
    chk("areset_ctrl", cfg_rd_data, 0);
    chk("areset_rdy", 32'(sif.g2p_rdy), 0);
    cfg_rd_en = 1'b0;
    sif.g2p_vld[0] = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
